// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// Round-robin, burst-aware arbiter for one AHB-Lite bus-matrix output stage.
// Shares one slave port between SYS, DMA and ACC; locks fixed bursts, hold-limits INCR.
module ahblite_busmatrix_arbiter_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       REQ_SYS,
  input  logic       REQ_DMA,
  input  logic       REQ_ACC,
  input  logic       HREADY_Outputstage,
  input  logic       HSEL_Outputstage,
  input  logic [1:0] HTRANS_Outputstage,
  input  logic [2:0] HBURST_Outputstage,
  output logic [1:0] PORT_SEL_ARBITER,
  output logic       PORT_NOSEL_ARBITER,
  output logic       ARB_LOCKED
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  localparam logic [1:0] M_NONE = 2'b00;
  localparam logic [1:0] M_SYS  = 2'b01;
  localparam logic [1:0] M_DMA  = 2'b10;
  localparam logic [1:0] M_ACC  = 2'b11;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_INCR  = 2'd3
  } state_t;

  // Request vector bit order: [0]=SYS, [1]=DMA, [2]=ACC; search starts after last.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] pick;
    pick = M_NONE;
    case (last)
      M_SYS: begin
        if (req[1])      pick = M_DMA;
        else if (req[2]) pick = M_ACC;
        else if (req[0]) pick = M_SYS;
        else             pick = M_NONE;
      end
      M_DMA: begin
        if (req[2])      pick = M_ACC;
        else if (req[0]) pick = M_SYS;
        else if (req[1]) pick = M_DMA;
        else             pick = M_NONE;
      end
      default: begin
        if (req[0])      pick = M_SYS;
        else if (req[1]) pick = M_DMA;
        else if (req[2]) pick = M_ACC;
        else             pick = M_NONE;
      end
    endcase
    return pick;
  endfunction

  function automatic logic [2:0] master_bit(input logic [1:0] m);
    logic [2:0] b;
    case (m)
      M_SYS:   b = 3'b001;
      M_DMA:   b = 3'b010;
      M_ACC:   b = 3'b100;
      default: b = 3'b000;
    endcase
    return b;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] port_sel_q, port_sel_d;
  logic       nosel_q, nosel_d;
  logic       locked_q, locked_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] rr_last_q, rr_last_d;

  logic [2:0] req_v;
  logic [2:0] ap_req;
  logic [1:0] pick;
  logic [7:0] hold_inc;
  logic       do_ap;
  logic       nonseq_s, seq_s, busy_s;

  assign req_v    = {REQ_ACC, REQ_DMA, REQ_SYS};
  assign nonseq_s = HSEL_Outputstage && (HTRANS_Outputstage == HT_NONSEQ);
  assign seq_s    = HSEL_Outputstage && (HTRANS_Outputstage == HT_SEQ);
  assign busy_s   = HSEL_Outputstage && (HTRANS_Outputstage == HT_BUSY);

  // Next-state, counters and grant; everything frozen while HREADY is low.
  always_comb begin
    state_d    = state_q;
    port_sel_d = port_sel_q;
    nosel_d    = nosel_q;
    beat_cnt_d = beat_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rr_last_d  = rr_last_q;
    ap_req     = req_v;
    pick       = M_NONE;
    do_ap      = 1'b0;
    hold_inc   = (hold_cnt_q >= MAX_HOLD_C) ? MAX_HOLD_C : (hold_cnt_q + 8'd1);

    if (HREADY_Outputstage) begin
      case (state_q)
        ST_IDLE: do_ap = 1'b1;
        ST_OWN: begin
          if (nonseq_s && (HBURST_Outputstage != 3'b000)) begin
            case (HBURST_Outputstage)
              3'b010, 3'b011: begin state_d = ST_BURST; beat_cnt_d = 4'd3;  end
              3'b100, 3'b101: begin state_d = ST_BURST; beat_cnt_d = 4'd7;  end
              3'b110, 3'b111: begin state_d = ST_BURST; beat_cnt_d = 4'd15; end
              default:        begin state_d = ST_INCR;  hold_cnt_d = 8'd1;  end
            endcase
          end else begin
            do_ap = 1'b1;
          end
        end
        ST_BURST: begin
          if (seq_s) begin
            if (beat_cnt_q > 4'd1) beat_cnt_d = beat_cnt_q - 4'd1;
            else                   do_ap = 1'b1;
          end else if (busy_s) begin
            beat_cnt_d = beat_cnt_q;
          end else begin
            do_ap = 1'b1;
          end
        end
        ST_INCR: begin
          if (seq_s || busy_s) begin
            hold_cnt_d = hold_inc;
            // Hold expired with someone else waiting: owner drops out of this AP.
            if ((hold_inc == MAX_HOLD_C) && ((req_v & ~master_bit(port_sel_q)) != 3'b000)) begin
              do_ap  = 1'b1;
              ap_req = req_v & ~master_bit(port_sel_q);
            end else begin
              do_ap = 1'b0;
            end
          end else begin
            do_ap = 1'b1;
          end
        end
        default: do_ap = 1'b1;
      endcase

      if (do_ap) begin
        pick       = rr_pick(ap_req, rr_last_q);
        beat_cnt_d = 4'd0;
        hold_cnt_d = 8'd0;
        if (pick != M_NONE) begin
          port_sel_d = pick;
          nosel_d    = 1'b0;
          rr_last_d  = pick;
          state_d    = ST_OWN;
        end else if (HSEL_Outputstage) begin
          state_d = nosel_q ? ST_IDLE : ST_OWN;
        end else begin
          port_sel_d = M_NONE;
          nosel_d    = 1'b1;
          state_d    = ST_IDLE;
        end
      end else begin
        pick = M_NONE;
      end
    end else begin
      state_d = state_q;
    end

    locked_d = (state_d == ST_BURST) || (state_d == ST_INCR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      port_sel_q <= M_NONE;
      nosel_q    <= 1'b1;
      locked_q   <= 1'b0;
      beat_cnt_q <= 4'd0;
      hold_cnt_q <= 8'd0;
      rr_last_q  <= M_ACC;
    end else begin
      state_q    <= state_d;
      port_sel_q <= port_sel_d;
      nosel_q    <= nosel_d;
      locked_q   <= locked_d;
      beat_cnt_q <= beat_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign PORT_SEL_ARBITER   = port_sel_q;
  assign PORT_NOSEL_ARBITER = nosel_q;
  assign ARB_LOCKED         = locked_q;

endmodule
